regfile_sb: RTL and testbench

Parametrised multi-port register file with scoreboard. It supersedes the fixed 32x32 single-write register bank. It holds the integer bank (r1..r15) and float bank (f0..f15, mapped at r16..r31) with a hardwired-zero r0, serves NRD combinational read ports and NWR write ports, and tracks per-register busy bits for long-latency producers (FPU, memory) so issue logic can stall on RAW hazards.

---
 rtl/regfile_sb.sv | 116 +++++++++++
 tb/tb_regfile_sb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with a hardwired-zero r0, write-through bypass and
// per-register busy bits that let issue logic stall on long-latency RAW hazards.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 3,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [NREGS-1:0]    busy_vec,
  output logic                wr_conflict
);

  logic [XLEN-1:0]  mem_p1 [NREGS];
  logic [NREGS-1:0] busy_p1;
  logic [NREGS-1:0] busy_nxt;
  logic             conflict_nxt;
  logic             claim_ok;

  logic [AW-1:0]    ra [NRD];
  logic [AW-1:0]    wa [NWR];
  logic [XLEN-1:0]  wd [NWR];
  logic             wv [NWR];

  function automatic logic in_range(input logic [AW-1:0] a);
    return (int'(a) < NREGS);
  endfunction

  // Address 0 is never stored, claimed or flagged when it is the zero register.
  function automatic logic writable(input logic [AW-1:0] a);
    return in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  for (genvar k = 0; k < NRD; k++) begin : g_rd_unpack
    assign ra[k] = rd_addr[k*AW +: AW];
  end

  for (genvar j = 0; j < NWR; j++) begin : g_wr_unpack
    assign wa[j] = wr_addr[j*AW +: AW];
    assign wd[j] = wr_data[j*XLEN +: XLEN];
    assign wv[j] = wr_en[j] && writable(wr_addr[j*AW +: AW]);
  end

  assign claim_ok = claim_en && writable(claim_addr);
  assign busy_vec = busy_p1;

  always_comb begin
    conflict_nxt = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wv[i] && wv[j] && (wa[i] == wa[j])) conflict_nxt = 1'b1;
      end
    end
  end

  // Retiring writes clear busy first so a same-cycle claim re-marks the register.
  always_comb begin
    busy_nxt = busy_p1;
    for (int j = 0; j < NWR; j++) begin
      if (wv[j]) busy_nxt[wa[j]] = 1'b0;
    end
    if (claim_ok) busy_nxt[claim_addr] = 1'b1;
  end

  // stage p1: architectural state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_p1[i] <= '0;
      busy_p1     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wv[j]) mem_p1[wa[j]] <= wd[j];
      end
      busy_p1     <= busy_nxt;
      wr_conflict <= conflict_nxt;
    end
  end

  // Read ports: ascending port scan makes the highest-index writer win.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (in_range(ra[k])) begin
        rd_data[k*XLEN +: XLEN] = mem_p1[ra[k]];
        rd_busy[k]              = busy_p1[ra[k]];
      end
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wv[j] && (wa[j] == ra[k])) begin
            rd_data[k*XLEN +: XLEN] = wd[j];
            if (!(claim_ok && (claim_addr == ra[k]))) rd_busy[k] = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (ra[k] == '0)) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_busy[k]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: table of per-cycle vectors with same-cycle read
// expectations plus a queue of expected post-edge busy/conflict state.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic [31:0] busy_vec;
  logic        wr_conflict;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_sb #(
    .XLEN(32), .NREGS(32), .NRD(3), .NWR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_vec(busy_vec), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ce;
    logic [4:0]  ca;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] ed0, ed1, ed2;
    logic [2:0]  eb;
    logic [31:0] ebusy;
    logic        econf;
  } vec_t;

  typedef struct {
    logic [31:0] busy;
    logic        conf;
    int          idx;
  } post_t;

  vec_t  vt[14];
  post_t q[$];

  function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0,
                              input logic [31:0] wd0, input logic [4:0] wa1,
                              input logic [31:0] wd1, input logic ce,
                              input logic [4:0] ca, input logic [4:0] ra0,
                              input logic [4:0] ra1, input logic [4:0] ra2,
                              input logic [31:0] ed0, input logic [31:0] ed1,
                              input logic [31:0] ed2, input logic [2:0] eb,
                              input logic [31:0] ebusy, input logic econf);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ce = ce; v.ca = ca; v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
    v.ed0 = ed0; v.ed1 = ed1; v.ed2 = ed2; v.eb = eb;
    v.ebusy = ebusy; v.econf = econf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  task automatic check_post();
    post_t p;
    if (q.size() > 0) begin
      p = q.pop_front();
      chk($sformatf("busy_vec after v%0d", p.idx), busy_vec, p.busy);
      chk($sformatf("wr_conflict after v%0d", p.idx), {31'b0, wr_conflict}, {31'b0, p.conf});
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    post_t p;
    @(negedge clk);
    wr_en      = v.we;
    wr_addr    = {v.wa1, v.wa0};
    wr_data    = {v.wd1, v.wd0};
    claim_en   = v.ce;
    claim_addr = v.ca;
    rd_addr    = {v.ra2, v.ra1, v.ra0};
    #1;
    chk($sformatf("v%0d rd_data0", idx), rd_data[31:0], v.ed0);
    chk($sformatf("v%0d rd_data1", idx), rd_data[63:32], v.ed1);
    chk($sformatf("v%0d rd_data2", idx), rd_data[95:64], v.ed2);
    chk($sformatf("v%0d rd_busy", idx), {29'b0, rd_busy}, {29'b0, v.eb});
    check_post();
    p.busy = v.ebusy;
    p.conf = v.econf;
    p.idx  = idx;
    q.push_back(p);
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle_inputs();

    vt[0]  = mk(2'b01,  5, 32'hDEADBEEF,  0, 32'h0,        1'b0,  0,  5,  5,  0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        3'b000, 32'h0,        1'b0);
    vt[1]  = mk(2'b00,  0, 32'h0,         0, 32'h0,        1'b0,  0,  5,  5,  3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        3'b000, 32'h0,        1'b0);
    vt[2]  = mk(2'b11, 20, 32'h11111111, 20, 32'h22222222, 1'b0,  0,  5, 20, 20, 32'hDEADBEEF, 32'h22222222, 32'h22222222, 3'b000, 32'h0,        1'b1);
    vt[3]  = mk(2'b00,  0, 32'h0,         0, 32'h0,        1'b0,  0, 20,  0,  1, 32'h22222222, 32'h0,        32'h0,        3'b000, 32'h0,        1'b0);
    vt[4]  = mk(2'b11,  0, 32'hFFFFFFFF,  0, 32'hFFFFFFFF, 1'b1,  0,  0,  0, 20, 32'h0,        32'h0,        32'h22222222, 3'b000, 32'h0,        1'b0);
    vt[5]  = mk(2'b00,  0, 32'h0,         0, 32'h0,        1'b0,  0,  0,  0,  0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h0,        1'b0);
    vt[6]  = mk(2'b00,  0, 32'h0,         0, 32'h0,        1'b1, 17, 17,  0,  0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h00020000, 1'b0);
    vt[7]  = mk(2'b00,  0, 32'h0,         0, 32'h0,        1'b0,  0, 17,  0, 17, 32'h0,        32'h0,        32'h0,        3'b101, 32'h00020000, 1'b0);
    vt[8]  = mk(2'b10,  0, 32'h0,        17, 32'h3F800000, 1'b0,  0, 17, 17,  5, 32'h3F800000, 32'h3F800000, 32'hDEADBEEF, 3'b000, 32'h0,        1'b0);
    vt[9]  = mk(2'b00,  0, 32'h0,         0, 32'h0,        1'b0,  0, 17, 17,  0, 32'h3F800000, 32'h3F800000, 32'h0,        3'b000, 32'h0,        1'b0);
    vt[10] = mk(2'b00,  0, 32'h0,         0, 32'h0,        1'b1,  9,  9,  0,  0, 32'h0,        32'h0,        32'h0,        3'b000, 32'h00000200, 1'b0);
    vt[11] = mk(2'b01,  9, 32'h00001234,  0, 32'h0,        1'b1,  9,  9,  9, 17, 32'h00001234, 32'h00001234, 32'h3F800000, 3'b011, 32'h00000200, 1'b0);
    vt[12] = mk(2'b00,  0, 32'h0,         0, 32'h0,        1'b0,  0,  9,  5,  9, 32'h00001234, 32'hDEADBEEF, 32'h00001234, 3'b101, 32'h00000200, 1'b0);
    vt[13] = mk(2'b11,  3, 32'h00000033,  4, 32'h00000044, 1'b0,  0,  3,  4,  9, 32'h00000033, 32'h00000044, 32'h00001234, 3'b100, 32'h00000200, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset busy_vec", busy_vec, 32'h0);
    chk("reset wr_conflict", {31'b0, wr_conflict}, 32'h0);

    // Every address on all three ports reads zero and idle after reset.
    for (int a = 0; a < 32; a++) begin
      logic [4:0] a0, a1, a2;
      @(negedge clk);
      a0 = 5'(a);
      a1 = 5'(31 - a);
      a2 = 5'((a + 7) % 32);
      rd_addr = {a2, a1, a0};
      #1;
      chk($sformatf("reset rd_data a=%0d", a), rd_data[31:0] | rd_data[63:32] | rd_data[95:64], 32'h0);
      chk($sformatf("reset rd_busy a=%0d", a), {29'b0, rd_busy}, 32'h0);
    end

    for (int i = 0; i < 14; i++) step(i, vt[i]);

    // Drain the last expectation and confirm r9 is busy and holds 0x1234.
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd9, 5'd9, 5'd9};
    #1;
    check_post();
    chk("pre-reset r9", rd_data[31:0], 32'h00001234);
    chk("pre-reset busy9", {31'b0, busy_vec[9]}, 32'h1);

    // Asynchronous reset takes effect before any clock edge.
    #1;
    rst = 1'b1;
    #1;
    chk("async rst busy_vec", busy_vec, 32'h0);
    chk("async rst r9", rd_data[31:0], 32'h0);
    chk("async rst rd_busy", {29'b0, rd_busy}, 32'h0);
    chk("async rst wr_conflict", {31'b0, wr_conflict}, 32'h0);

    // A write and claim presented while reset is held are discarded.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h00005555};
    claim_en = 1'b1; claim_addr = 5'd12;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("post-rst r9", rd_data[31:0], 32'h0);
    chk("post-rst busy_vec", busy_vec, 32'h0);
    @(negedge clk);
    rd_addr = {5'd12, 5'd12, 5'd9};
    #1;
    chk("post-rst r12 busy", {29'b0, rd_busy}, 32'h0);
    chk("post-rst wr_conflict", {31'b0, wr_conflict}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
